// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums a job of len unsigned 16-bit products from an upstream
//               8x8 multiplier. The result is held with a sticky overflow flag
//               until a valid/ready handshake consumes it.
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             p_valid,
  input  logic [15:0]      p_data,
  output logic             p_ready,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic             acc_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] c_ONE = LEN_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [LEN_W-1:0] r_remaining;

  logic             w_beat;
  logic [ACC_W:0]   w_sum;

  // A beat is taken only in ACCUM; p_ready is decoded from state alone.
  assign w_beat = (r_state == S_ACCUM) && p_valid;
  // One extra bit on the adder exposes the carry-out of bit ACC_W-1.
  assign w_sum  = {1'b0, r_acc} + (ACC_W+1)'(p_data);

  // State register plus accumulator, overflow and remaining-count datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (start) begin
          // Clear on every accepted start so a zero-length job reports 0.
          r_acc       <= '0;
          r_ovf       <= 1'b0;
          r_remaining <= len;
        end
      end else if (w_beat) begin
        r_acc       <= w_sum[ACC_W-1:0];
        r_ovf       <= r_ovf | w_sum[ACC_W];
        r_remaining <= r_remaining - c_ONE;
      end
    end
  end

  // Next-state decode: start only matters in IDLE, acc_ready only in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (len != '0) ? S_ACCUM : S_HOLD;
        end
      end
      S_ACCUM: begin
        if (w_beat && (r_remaining == c_ONE)) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (acc_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign p_ready   = (r_state == S_ACCUM);
  assign acc_valid = (r_state == S_HOLD);
  assign busy      = (r_state != S_IDLE);
  assign acc_data  = r_acc;
  assign acc_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_accumulator
// Description : Directed self-checking bench for product_accumulator. A
//               default instance and an ACC_W=16 instance share the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        p_valid;
  logic [15:0] p_data;
  logic        acc_ready;

  logic        p_ready,   p_ready16;
  logic        acc_valid, acc_valid16;
  logic [23:0] acc_data;
  logic [15:0] acc_data16;
  logic        acc_ovf,   acc_ovf16;
  logic        busy,      busy16;

  int n_checks;
  int n_errors;

  product_accumulator u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .p_valid   (p_valid),
    .p_data    (p_data),
    .p_ready   (p_ready),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_data  (acc_data),
    .acc_ovf   (acc_ovf),
    .busy      (busy)
  );

  product_accumulator #(.ACC_W(16), .LEN_W(8)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .p_valid   (p_valid),
    .p_data    (p_data),
    .p_ready   (p_ready16),
    .acc_valid (acc_valid16),
    .acc_ready (acc_ready),
    .acc_data  (acc_data16),
    .acc_ovf   (acc_ovf16),
    .busy      (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled at this point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
  endtask

  // Present one product for one cycle, then idle p_valid for 'gaps' cycles
  // with junk on p_data so any bubble capture corrupts the sum.
  task automatic send_beat(input logic [15:0] d, input int gaps);
    p_valid = 1'b1;
    p_data  = d;
    step();
    p_valid = 1'b0;
    p_data  = 16'hFFFF;
    for (int g = 0; g < gaps; g++) step();
  endtask

  task automatic consume();
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    p_valid   = 1'b0;
    p_data    = 16'd0;
    acc_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_p_ready",   32'(p_ready),   32'd0);
    chk("rst_acc_valid", 32'(acc_valid), 32'd0);
    chk("rst_acc_data",  32'(acc_data),  32'd0);
    chk("rst_acc_ovf",   32'(acc_ovf),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    step();

    // len=3, 100+200+300 back-to-back
    begin_job(8'd3);
    chk("t1_p_ready", 32'(p_ready), 32'd1);
    chk("t1_busy",    32'(busy),    32'd1);
    send_beat(16'd100, 0);
    send_beat(16'd200, 0);
    chk("t1_valid_early", 32'(acc_valid), 32'd0);
    send_beat(16'd300, 0);
    chk("t1_valid", 32'(acc_valid), 32'd1);
    chk("t1_data",  32'(acc_data),  32'd600);
    chk("t1_ovf",   32'(acc_ovf),   32'd0);
    consume();
    chk("t1_valid_after", 32'(acc_valid), 32'd0);
    chk("t1_busy_after",  32'(busy),      32'd0);

    // len=4, 65025 with 2-cycle bubbles; len changed mid-job
    begin_job(8'd4);
    len = 8'd1;
    send_beat(16'd65025, 2);
    send_beat(16'd65025, 2);
    send_beat(16'd65025, 2);
    chk("t2_valid_early", 32'(acc_valid), 32'd0);
    chk("t2_partial",     32'(acc_data),  32'd195075);
    send_beat(16'd65025, 2);
    chk("t2_valid", 32'(acc_valid), 32'd1);
    chk("t2_data",  32'(acc_data),  32'd260100);
    chk("t2_ovf",   32'(acc_ovf),   32'd0);
    send_beat(16'd50, 0);
    chk("t2_no_extra_ready", 32'(p_ready),  32'd0);
    chk("t2_no_extra_data",  32'(acc_data), 32'd260100);
    consume();
    chk("t2_idle", 32'(busy), 32'd0);

    // len=0 goes straight to HOLD and waits for acc_ready
    begin_job(8'd0);
    chk("t3_valid",   32'(acc_valid), 32'd1);
    chk("t3_data",    32'(acc_data),  32'd0);
    chk("t3_ovf",     32'(acc_ovf),   32'd0);
    chk("t3_p_ready", 32'(p_ready),   32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold_valid", 32'(acc_valid), 32'd1);
      chk("t3_hold_data",  32'(acc_data),  32'd0);
    end
    consume();
    chk("t3_valid_after", 32'(acc_valid), 32'd0);
    chk("t3_busy_after",  32'(busy),      32'd0);

    // Overflow on the 16-bit instance: 65535 + 2 = 65537 -> 1 with carry
    begin_job(8'd2);
    send_beat(16'd65535, 0);
    send_beat(16'd2, 0);
    chk("t4_valid16", 32'(acc_valid16), 32'd1);
    chk("t4_data16",  32'(acc_data16),  32'd1);
    chk("t4_ovf16",   32'(acc_ovf16),   32'd1);
    chk("t4_data24",  32'(acc_data),    32'd65537);
    chk("t4_ovf24",   32'(acc_ovf),     32'd0);
    consume();

    // Reset mid-job discards the partial sum
    begin_job(8'd5);
    send_beat(16'd10, 0);
    send_beat(16'd20, 0);
    rst_n = 1'b0;
    step();
    chk("t5_p_ready",   32'(p_ready),   32'd0);
    chk("t5_acc_valid", 32'(acc_valid), 32'd0);
    chk("t5_acc_data",  32'(acc_data),  32'd0);
    chk("t5_acc_ovf",   32'(acc_ovf),   32'd0);
    chk("t5_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    step();
    begin_job(8'd1);
    send_beat(16'd7, 0);
    chk("t5_new_valid", 32'(acc_valid), 32'd1);
    chk("t5_new_data",  32'(acc_data),  32'd7);
    consume();

    // start ignored in ACCUM and HOLD; acc_ready ignored in ACCUM
    begin_job(8'd2);
    acc_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd7;
    send_beat(16'd5, 0);
    start = 1'b0;
    chk("t6_still_accum", 32'(p_ready), 32'd1);
    send_beat(16'd6, 0);
    acc_ready = 1'b0;
    chk("t6_valid", 32'(acc_valid), 32'd1);
    chk("t6_data",  32'(acc_data),  32'd11);
    start = 1'b1;
    len   = 8'd0;
    step();
    start = 1'b0;
    chk("t6_hold_valid", 32'(acc_valid), 32'd1);
    chk("t6_hold_data",  32'(acc_data),  32'd11);
    consume();
    chk("t6_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24, giving the accumulator width in bits; legal range 16..32.
REQ-002 The block SHALL have parameter LEN_W, default 8, giving the width of the product-count field.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset; one clock, reset is synchronous and active-low.
REQ-005 Port start, input, 1 bit: single-cycle request to begin an accumulation job.
REQ-006 Port len, input, LEN_W bits: number of products in the job; sampled only when start is accepted.
REQ-007 Port p_valid, input, 1 bit: p_data holds a valid 16-bit product from the upstream 8x8 array multiplier.
REQ-008 Port p_data, input, 16 bits: unsigned product P[15:0].
REQ-009 Port p_ready, output, 1 bit: the block accepts a product this cycle.
REQ-010 Port acc_valid, output, 1 bit: result available.
REQ-011 Port acc_ready, input, 1 bit: downstream consumes the result.
REQ-012 Port acc_data, output, ACC_W bits: accumulated sum.
REQ-013 Port acc_ovf, output, 1 bit: sticky overflow flag for the current result.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-016 In IDLE, with start=1 and len!=0: clear acc to 0, clear ovf, load remaining=len, enter ACCUM on the next cycle.
REQ-017 In IDLE, with start=1 and len==0: enter HOLD with acc_data=0 and acc_ovf=0.
REQ-018 start SHALL be ignored in ACCUM and HOLD.
REQ-019 p_ready SHALL be 1 exactly in ACCUM and SHALL be a registered or purely state-decoded signal with no combinational path from p_valid.
REQ-020 A beat is accepted when p_valid=1 and p_ready=1 on a rising clk edge; otherwise acc, ovf, and remaining hold.
REQ-021 On an accepted beat: acc <= acc + zero-extended p_data, modulo 2^ACC_W.
REQ-022 On an accepted beat: ovf <= ovf OR carry-out of bit ACC_W-1.
REQ-023 On an accepted beat: remaining decrements by 1.
REQ-024 On the accepted beat with remaining==1, the next state SHALL be HOLD; acc_valid SHALL rise the cycle after the last beat (latency 1).
REQ-025 In HOLD: acc_valid=1, and acc_data and acc_ovf SHALL be stable until the handshake.
REQ-026 In HOLD, on acc_ready=1 the next state SHALL be IDLE, and acc_valid SHALL be 0 the following cycle.
REQ-027 acc_ready SHALL be ignored outside HOLD.
REQ-028 Outside HOLD, acc_data and acc_ovf SHALL show the running accumulator and ovf values.
REQ-029 p_valid gaps (bubbles) in ACCUM SHALL stall without loss or duplication.
REQ-030 len is captured at start; later changes to len SHALL have no effect on the running job.
REQ-031 With default parameters (255 x 65025 < 2^24) acc_ovf SHALL never assert.

Reset
REQ-032 While rst_n=0 at a clk edge, the block SHALL return to IDLE with acc=0, ovf=0, remaining=0.
REQ-033 Reset outputs SHALL be: p_ready=0, acc_valid=0, acc_data=0, acc_ovf=0, busy=0.
REQ-034 Reset asserted mid-job (ACCUM or HOLD) SHALL discard the partial sum and emit no result.

Verification
REQ-035 The bench SHALL cover: start, len=3, products 100, 200, 300 back-to-back -> acc_valid one cycle after the third beat, acc_data=600, acc_ovf=0.
REQ-036 The bench SHALL cover: start, len=4, all products 65025 with a 2-cycle p_valid bubble between each -> acc_data=260100, no extra or missing beats.
REQ-037 The bench SHALL cover: start, len=0 -> HOLD next cycle with acc_data=0; acc_ready held 0 for 5 cycles -> acc_valid and acc_data stable; acc_ready=1 -> IDLE.
REQ-038 The bench SHALL cover: ACC_W=16, len=2, products 65535 and 2 -> acc_data=1, acc_ovf=1.
REQ-039 The bench SHALL cover: len=5 with rst_n=0 after the 2nd beat -> all outputs 0 next cycle; a new job with len=1, product 7 -> acc_data=7.
REQ-040 The bench SHALL cover: start pulsed during ACCUM and during HOLD -> ignored, and the result equals that of the original job.
